// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - IF/MEM arbiter for one SRAM-like bus port; define SRAM_ARB_RR_EN for round-robin grant
module sram_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_req,
    input  logic [AW-1:0]   inst_addr,
    output logic [DW-1:0]   inst_rdata,
    output logic            inst_valid,
    input  logic            data_req,
    input  logic [DW/8-1:0] data_wen,
    input  logic [AW-1:0]   data_addr,
    input  logic [DW-1:0]   data_wdata,
    output logic [DW-1:0]   data_rdata,
    output logic            data_valid,
    output logic            bus_req,
    output logic            bus_wr,
    output logic [DW/8-1:0] bus_wstrb,
    output logic [AW-1:0]   bus_addr,
    output logic [DW-1:0]   bus_wdata,
    input  logic            bus_addr_ok,
    input  logic [DW-1:0]   bus_rdata,
    input  logic            bus_data_ok,
    output logic            stallreq_if,
    output logic            stallreq_mem
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_t;

    state_t state;
    owner_t owner;
    owner_t pick;
    logic   inst_elig;
    logic   data_elig;
    logic   finish;

    // A requester is masked while its valid is high, since it still holds req that cycle.
    assign inst_elig    = inst_req & ~inst_valid;
    assign data_elig    = data_req & ~data_valid;
    assign stallreq_if  = inst_elig;
    assign stallreq_mem = data_elig;

    assign finish = ((state == ADDR) && bus_addr_ok && bus_data_ok) ||
                    ((state == DATA) && bus_data_ok);

`ifdef SRAM_ARB_RR_EN
    owner_t last_grant;

    always_comb begin
        pick = OWN_INST;
        if (inst_elig && data_elig)
            pick = (last_grant == OWN_INST) ? OWN_DATA : OWN_INST;
        else if (data_elig)
            pick = OWN_DATA;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_grant <= OWN_INST;
        else if ((state == IDLE) && (inst_elig || data_elig))
            last_grant <= pick;
    end
`else
    always_comb begin
        pick = data_elig ? OWN_DATA : OWN_INST;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= OWN_INST;
            bus_req    <= 1'b0;
            bus_wr     <= 1'b0;
            bus_wstrb  <= '0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            inst_valid <= 1'b0;
            data_valid <= 1'b0;
            inst_rdata <= '0;
            data_rdata <= '0;
        end else begin
            inst_valid <= 1'b0;
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (inst_elig || data_elig) begin
                        owner   <= pick;
                        state   <= ADDR;
                        bus_req <= 1'b1;
                        if (pick == OWN_DATA) begin
                            bus_wr    <= |data_wen;
                            bus_wstrb <= data_wen;
                            bus_addr  <= data_addr;
                            bus_wdata <= data_wdata;
                        end else begin
                            bus_wr    <= 1'b0;
                            bus_wstrb <= '0;
                            bus_addr  <= inst_addr;
                            bus_wdata <= '0;
                        end
                    end
                end
                ADDR: begin
                    if (bus_addr_ok) begin
                        bus_req <= 1'b0;
                        state   <= bus_data_ok ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (bus_data_ok)
                        state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    bus_req <= 1'b0;
                end
            endcase

            // Writes leave the owner's rdata untouched.
            if (finish) begin
                if (owner == OWN_INST) begin
                    inst_valid <= 1'b1;
                    if (!bus_wr)
                        inst_rdata <= bus_rdata;
                end else begin
                    data_valid <= 1'b1;
                    if (!bus_wr)
                        data_rdata <= bus_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic [31:0] inst_rdata;
    logic        inst_valid;
    logic        data_req = 1'b0;
    logic [3:0]  data_wen = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic [31:0] data_rdata;
    logic        data_valid;
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        bus_data_ok = 1'b0;
    logic        stallreq_if;
    logic        stallreq_mem;

    int tests_run = 0;
    int fails = 0;

    sram_port_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_valid(inst_valid),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_valid(data_valid),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_rdata(bus_rdata),
        .bus_data_ok(bus_data_ok), .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        tick();
        tick();
        chk("rst_bus_req", 32'(bus_req), 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("rst_data_valid", 32'(data_valid), 32'h0);
        chk("rst_inst_rdata", inst_rdata, 32'h0);
        chk("rst_data_rdata", data_rdata, 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_stall_if", 32'(stallreq_if), 32'h0);
        chk("rst_stall_mem", 32'(stallreq_mem), 32'h0);
        rst = 1'b1;
        tick();

        // Single fetch: addr_ok with bus_req, data_ok two cycles later
        inst_req = 1'b1;
        inst_addr = 32'hBFC00000;
        #1;
        chk("fetch_stall_pre", 32'(stallreq_if), 32'h1);
        tick();
        chk("fetch_bus_req", 32'(bus_req), 32'h1);
        chk("fetch_bus_addr", bus_addr, 32'hBFC00000);
        chk("fetch_bus_wr", 32'(bus_wr), 32'h0);
        chk("fetch_bus_wstrb", 32'(bus_wstrb), 32'h0);
        bus_addr_ok = 1'b1;
        tick();
        chk("fetch_bus_req_drop", 32'(bus_req), 32'h0);
        bus_addr_ok = 1'b0;
        tick();
        chk("fetch_wait_valid", 32'(inst_valid), 32'h0);
        chk("fetch_wait_stall", 32'(stallreq_if), 32'h1);
        bus_data_ok = 1'b1;
        bus_rdata = 32'h24010001;
        tick();
        chk("fetch_valid", 32'(inst_valid), 32'h1);
        chk("fetch_rdata", inst_rdata, 32'h24010001);
        chk("fetch_stall_done", 32'(stallreq_if), 32'h0);
        chk("fetch_data_valid", 32'(data_valid), 32'h0);
        bus_data_ok = 1'b0;
        tick();
        chk("fetch_valid_once", 32'(inst_valid), 32'h0);
        chk("fetch_no_dup_req", 32'(bus_req), 32'h0);
        inst_req = 1'b0;
        tick();

        // Store: write strobes, write data, rdata unchanged
        data_req = 1'b1;
        data_wen = 4'b0011;
        data_addr = 32'h80000010;
        data_wdata = 32'hDEADBEEF;
        tick();
        chk("store_bus_req", 32'(bus_req), 32'h1);
        chk("store_bus_wr", 32'(bus_wr), 32'h1);
        chk("store_bus_wstrb", 32'(bus_wstrb), 32'h3);
        chk("store_bus_addr", bus_addr, 32'h80000010);
        chk("store_bus_wdata", bus_wdata, 32'hDEADBEEF);
        bus_addr_ok = 1'b1;
        bus_data_ok = 1'b1;
        bus_rdata = 32'hFFFFFFFF;
        tick();
        chk("store_valid", 32'(data_valid), 32'h1);
        chk("store_rdata_kept", data_rdata, 32'h0);
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        tick();
        chk("store_valid_once", 32'(data_valid), 32'h0);
        chk("store_no_dup_req", 32'(bus_req), 32'h0);
        data_req = 1'b0;
        data_wen = 4'b0000;
        tick();

        // Simultaneous requests: data first, inst granted in data's valid cycle
        inst_req = 1'b1;
        inst_addr = 32'h00000100;
        data_req = 1'b1;
        data_addr = 32'h00000200;
        tick();
        chk("both_first_addr", bus_addr, 32'h00000200);
        chk("both_first_wr", 32'(bus_wr), 32'h0);
        bus_addr_ok = 1'b1;
        bus_data_ok = 1'b1;
        bus_rdata = 32'hAAAA0001;
        tick();
        chk("both_data_valid", 32'(data_valid), 32'h1);
        chk("both_data_rdata", data_rdata, 32'hAAAA0001);
        chk("both_inst_wait", 32'(inst_valid), 32'h0);
        bus_rdata = 32'hBBBB0002;
        tick();
        chk("both_second_req", 32'(bus_req), 32'h1);
        chk("both_second_addr", bus_addr, 32'h00000100);
        chk("both_idle_dataok_ign", 32'(inst_valid), 32'h0);
        chk("both_data_valid_once", 32'(data_valid), 32'h0);
        data_req = 1'b0;
        tick();
        chk("both_inst_valid", 32'(inst_valid), 32'h1);
        chk("both_inst_rdata", inst_rdata, 32'hBBBB0002);
        chk("both_no_data_valid", 32'(data_valid), 32'h0);
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        tick();
        chk("both_done_req", 32'(bus_req), 32'h0);
        inst_req = 1'b0;
        tick();

        // Back-pressure: five cycles without addr_ok
        data_req = 1'b1;
        data_addr = 32'h00000300;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_req_%0d", i), 32'(bus_req), 32'h1);
            chk($sformatf("bp_addr_%0d", i), bus_addr, 32'h00000300);
            chk($sformatf("bp_stall_%0d", i), 32'(stallreq_mem), 32'h1);
            tick();
        end
        bus_addr_ok = 1'b1;
        tick();
        chk("bp_data_phase_req", 32'(bus_req), 32'h0);
        chk("bp_data_phase_stall", 32'(stallreq_mem), 32'h1);
        bus_addr_ok = 1'b0;

        // Reset in DATA state, then a spurious data_ok
        rst = 1'b0;
        #1;
        chk("rst_mid_bus_req", 32'(bus_req), 32'h0);
        chk("rst_mid_bus_addr", bus_addr, 32'h0);
        chk("rst_mid_data_rdata", data_rdata, 32'h0);
        chk("rst_mid_data_valid", 32'(data_valid), 32'h0);
        chk("rst_mid_inst_valid", 32'(inst_valid), 32'h0);
        data_req = 1'b0;
        tick();
        rst = 1'b1;
        bus_data_ok = 1'b1;
        bus_rdata = 32'hCAFEF00D;
        tick();
        chk("spur_data_valid_0", 32'(data_valid), 32'h0);
        chk("spur_inst_valid_0", 32'(inst_valid), 32'h0);
        tick();
        chk("spur_data_valid_1", 32'(data_valid), 32'h0);
        chk("spur_bus_req", 32'(bus_req), 32'h0);
        chk("spur_data_rdata", data_rdata, 32'h0);
        bus_data_ok = 1'b0;
        tick();

        // Same-cycle addr_ok/data_ok: 2-cycle round trip, then back in IDLE
        inst_req = 1'b1;
        inst_addr = 32'h00000400;
        tick();
        chk("rt_bus_req", 32'(bus_req), 32'h1);
        bus_addr_ok = 1'b1;
        bus_data_ok = 1'b1;
        bus_rdata = 32'h12345678;
        tick();
        chk("rt_inst_valid", 32'(inst_valid), 32'h1);
        chk("rt_inst_rdata", inst_rdata, 32'h12345678);
        chk("rt_bus_req_drop", 32'(bus_req), 32'h0);
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        data_req = 1'b1;
        data_addr = 32'h00000500;
        tick();
        chk("rt_idle_regrant", 32'(bus_req), 32'h1);
        chk("rt_idle_addr", bus_addr, 32'h00000500);
        chk("rt_inst_valid_once", 32'(inst_valid), 32'h0);
        inst_req = 1'b0;
        bus_addr_ok = 1'b1;
        bus_data_ok = 1'b1;
        bus_rdata = 32'h0BADF00D;
        tick();
        chk("rt_data_valid", 32'(data_valid), 32'h1);
        chk("rt_data_rdata", data_rdata, 32'h0BADF00D);
        chk("rt_inst_rdata_hold", inst_rdata, 32'h12345678);
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        tick();
        data_req = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
